// File: rtl/mem_req_arbiter_pkg.sv
// Shared opcodes, FSM/owner encodings and the MU access descriptor for the memory request arbiter.
package mem_req_arbiter_pkg;

  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_DRAIN = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LSB  = 2'd2;

  // Instruction fetches are always a full word read.
  localparam logic [2:0] FETCH_OP = 3'b010;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  op;
    logic [31:0] wdata;
  } mu_desc_t;

  function automatic mu_desc_t fetch_desc(input logic [31:0] pc);
    mu_desc_t d;
    d.wr    = 1'b0;
    d.addr  = pc;
    d.op    = FETCH_OP;
    d.wdata = 32'd0;
    return d;
  endfunction

  function automatic mu_desc_t lsb_desc(input logic [6:0]  op_type,
                                        input logic [2:0]  op,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata);
    mu_desc_t d;
    d.wr    = (op_type == S_TYPE);
    d.addr  = addr;
    d.op    = op;
    d.wdata = wdata;
    return d;
  endfunction

endpackage

// File: rtl/mem_grant_sel.sv
// Combinational grant selection: LSB has priority unless IF has been starved for STARVE_LIMIT grants.
module mem_grant_sel #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             if_req,
  input  logic             lsb_req,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             flush,
  output logic             grant_if,
  output logic             grant_lsb
);

  logic if_starved;
  logic lsb_wins;

  assign if_starved = if_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign lsb_wins   = lsb_req && !if_starved;

  // A flush cycle in IDLE grants nobody, so a stale request cannot slip past the flush.
  assign grant_lsb  = !flush && lsb_wins;
  assign grant_if   = !flush && if_req && !lsb_wins;

endmodule

// File: rtl/mem_req_arbiter.sv
// Sequences the byte-serial memory unit between instruction fetch and the load/store buffer.
// One access in flight; ROB flush cancels fetches and loads, issued stores always complete.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,

  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ack,
  output logic        if_done,
  output logic [31:0] if_inst,
  output logic [31:0] if_inst_addr,

  input  logic        lsb_req,
  input  logic [6:0]  lsb_op_type,
  input  logic [2:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ack,
  output logic        lsb_done,
  output logic        lsb_is_load,
  output logic [31:0] lsb_rdata,

  output logic        mu_start,
  output logic        mu_wr,
  output logic [31:0] mu_addr,
  output logic [2:0]  mu_op,
  output logic [31:0] mu_wdata,
  input  logic        mu_done,
  input  logic [31:0] mu_rdata
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  mu_desc_t         desc_q, desc_d;
  logic             is_load_q, is_load_d;

  logic             mu_start_q, mu_start_d;
  logic             if_ack_q, if_ack_d;
  logic             lsb_ack_q, lsb_ack_d;
  logic             if_done_q, if_done_d;
  logic [31:0]      if_inst_q, if_inst_d;
  logic [31:0]      if_inst_addr_q, if_inst_addr_d;
  logic             lsb_done_q, lsb_done_d;
  logic             lsb_is_load_q, lsb_is_load_d;
  logic [31:0]      lsb_rdata_q, lsb_rdata_d;

  logic             grant_if;
  logic             grant_lsb;
  logic             flush_kill;

  mem_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_grant_sel (
    .if_req     (if_req),
    .lsb_req    (lsb_req),
    .starve_cnt (starve_cnt_q),
    .flush      (rob_clear_up),
    .grant_if   (grant_if),
    .grant_lsb  (grant_lsb)
  );

  // Fetches and loads are speculative and die on a flush; a store has already committed.
  assign flush_kill = rob_clear_up && ((owner_q == OWN_IF) || !desc_q.wr);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    starve_cnt_d   = starve_cnt_q;
    desc_d         = desc_q;
    is_load_d      = is_load_q;
    mu_start_d     = 1'b0;
    if_ack_d       = 1'b0;
    lsb_ack_d      = 1'b0;
    if_done_d      = 1'b0;
    if_inst_d      = 32'd0;
    if_inst_addr_d = if_inst_addr_q;
    lsb_done_d     = 1'b0;
    lsb_is_load_d  = 1'b0;
    lsb_rdata_d    = 32'd0;

    case (state_q)
      ARB_IDLE: begin
        if (!if_req) begin
          starve_cnt_d = '0;
        end
        if (grant_lsb) begin
          desc_d     = lsb_desc(lsb_op_type, lsb_op, lsb_addr, lsb_wdata);
          is_load_d  = (lsb_op_type == LD_TYPE);
          owner_d    = OWN_LSB;
          state_d    = ARB_ISSUE;
          mu_start_d = 1'b1;
          lsb_ack_d  = 1'b1;
          if (if_req && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (grant_if) begin
          desc_d       = fetch_desc(if_pc);
          is_load_d    = 1'b0;
          owner_d      = OWN_IF;
          state_d      = ARB_ISSUE;
          mu_start_d   = 1'b1;
          if_ack_d     = 1'b1;
          starve_cnt_d = '0;
        end
      end

      ARB_ISSUE: begin
        state_d = flush_kill ? ARB_DRAIN : ARB_WAIT;
      end

      ARB_WAIT: begin
        if (flush_kill) begin
          // A flush arriving with mu_done swallows the result outright.
          if (mu_done) begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
          end else begin
            state_d = ARB_DRAIN;
          end
        end else if (mu_done) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_done_d      = 1'b1;
            if_inst_d      = mu_rdata;
            if_inst_addr_d = desc_q.addr;
          end else begin
            lsb_done_d    = 1'b1;
            lsb_is_load_d = is_load_q;
            lsb_rdata_d   = is_load_q ? mu_rdata : 32'd0;
          end
        end
      end

      ARB_DRAIN: begin
        if (mu_done) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWN_NONE;
      starve_cnt_q   <= '0;
      desc_q         <= '0;
      is_load_q      <= 1'b0;
      mu_start_q     <= 1'b0;
      if_ack_q       <= 1'b0;
      lsb_ack_q      <= 1'b0;
      if_done_q      <= 1'b0;
      if_inst_q      <= 32'd0;
      if_inst_addr_q <= 32'd0;
      lsb_done_q     <= 1'b0;
      lsb_is_load_q  <= 1'b0;
      lsb_rdata_q    <= 32'd0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      starve_cnt_q   <= starve_cnt_d;
      desc_q         <= desc_d;
      is_load_q      <= is_load_d;
      mu_start_q     <= mu_start_d;
      if_ack_q       <= if_ack_d;
      lsb_ack_q      <= lsb_ack_d;
      if_done_q      <= if_done_d;
      if_inst_q      <= if_inst_d;
      if_inst_addr_q <= if_inst_addr_d;
      lsb_done_q     <= lsb_done_d;
      lsb_is_load_q  <= lsb_is_load_d;
      lsb_rdata_q    <= lsb_rdata_d;
    end
  end

  assign if_ack       = if_ack_q;
  assign if_done      = if_done_q;
  assign if_inst      = if_inst_q;
  assign if_inst_addr = if_inst_addr_q;
  assign lsb_ack      = lsb_ack_q;
  assign lsb_done     = lsb_done_q;
  assign lsb_is_load  = lsb_is_load_q;
  assign lsb_rdata    = lsb_rdata_q;
  assign mu_start     = mu_start_q;
  assign mu_wr        = desc_q.wr;
  assign mu_addr      = desc_q.addr;
  assign mu_op        = desc_q.op;
  assign mu_wdata     = desc_q.wdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: MU responder, transaction-level reference model, literal checks.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int STARVE = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear_up = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        lsb_req = 1'b0;
  logic [6:0]  lsb_op_type = 7'd0;
  logic [2:0]  lsb_op = 3'd0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic        mu_done = 1'b0;
  logic [31:0] mu_rdata = 32'd0;

  logic        if_ack, if_done, lsb_ack, lsb_done, lsb_is_load, mu_start, mu_wr;
  logic [31:0] if_inst, if_inst_addr, lsb_rdata, mu_addr, mu_wdata;
  logic [2:0]  mu_op;

  mem_req_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(3)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear_up (rob_clear_up),
    .if_req       (if_req),
    .if_pc        (if_pc),
    .if_ack       (if_ack),
    .if_done      (if_done),
    .if_inst      (if_inst),
    .if_inst_addr (if_inst_addr),
    .lsb_req      (lsb_req),
    .lsb_op_type  (lsb_op_type),
    .lsb_op       (lsb_op),
    .lsb_addr     (lsb_addr),
    .lsb_wdata    (lsb_wdata),
    .lsb_ack      (lsb_ack),
    .lsb_done     (lsb_done),
    .lsb_is_load  (lsb_is_load),
    .lsb_rdata    (lsb_rdata),
    .mu_start     (mu_start),
    .mu_wr        (mu_wr),
    .mu_addr      (mu_addr),
    .mu_op        (mu_op),
    .mu_wdata     (mu_wdata),
    .mu_done      (mu_done),
    .mu_rdata     (mu_rdata)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
  endtask

  // MU responder: accepts a start on a live cycle, answers mu_lat live cycles later.
  int          mu_lat = 2;
  logic [31:0] mu_val = 32'd0;
  int          mu_rem = 0;
  logic        done_nx = 1'b0;
  int          n_starts = 0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      mu_rem  = 0;
      done_nx = 1'b0;
    end else if (rdy_in) begin
      done_nx = 1'b0;
      if (mu_rem > 0) begin
        mu_rem--;
        if (mu_rem == 0) done_nx = 1'b1;
      end
      if (mu_start) begin
        n_starts++;
        if (mu_lat == 0) done_nx = 1'b1;
        else mu_rem = mu_lat;
      end
    end
  end

  always @(posedge clk_in) begin
    #1;
    mu_done  = done_nx;
    mu_rdata = done_nx ? mu_val : 32'hBAD0_BAD0;
  end

  // Reference model: tracks one transaction (who owns it, cancelled or not) and predicts the
  // outputs visible after the next clock edge.
  bit          model_ok = 1'b0;
  bit          m_busy, m_issuing, m_cancel, m_is_if, m_store, m_load;
  int          m_starve;
  logic        x_start, x_if_ack, x_lsb_ack, x_if_done, x_lsb_done, x_is_load, x_wr;
  logic [31:0] x_if_inst, x_if_addr, x_lsb_rdata, x_addr, x_wdata;
  logic [2:0]  x_op;

  always @(negedge clk_in) begin
    if (model_ok) begin
      check("mu_start", mu_start, x_start);
      check("if_ack", if_ack, x_if_ack);
      check("lsb_ack", lsb_ack, x_lsb_ack);
      check("if_done", if_done, x_if_done);
      check("lsb_done", lsb_done, x_lsb_done);
      check("lsb_is_load", lsb_is_load, x_is_load);
      check("if_inst", if_inst, x_if_inst);
      check("lsb_rdata", lsb_rdata, x_lsb_rdata);
      check("mu_wr", mu_wr, x_wr);
      check("mu_addr", mu_addr, x_addr);
      check("mu_op", mu_op, x_op);
      if (x_wr) check("mu_wdata", mu_wdata, x_wdata);
      if (x_if_done) check("if_inst_addr", if_inst_addr, x_if_addr);
      if (if_done && rdy_in)  $display("txn fetch addr=%08h inst=%08h cycle %0d", if_inst_addr, if_inst, cyc);
      if (lsb_done && rdy_in) $display("txn lsb load=%0b rdata=%08h cycle %0d", lsb_is_load, lsb_rdata, cyc);
    end

    if (rst_in) begin
      model_ok = 1'b1;
      {m_busy, m_issuing, m_cancel, m_is_if, m_store, m_load} = '0;
      m_starve = 0;
      {x_start, x_if_ack, x_lsb_ack, x_if_done, x_lsb_done, x_is_load, x_wr} = '0;
      x_if_inst = 0; x_if_addr = 0; x_lsb_rdata = 0; x_addr = 0; x_wdata = 0; x_op = 0;
    end else if (rdy_in) begin
      {x_start, x_if_ack, x_lsb_ack, x_if_done, x_lsb_done, x_is_load} = '0;
      x_if_inst = 0; x_lsb_rdata = 0;
      if (!m_busy) begin
        if (!if_req) m_starve = 0;
        if (!rob_clear_up && lsb_req && !(if_req && m_starve == STARVE)) begin
          m_busy = 1; m_issuing = 1; m_cancel = 0; m_is_if = 0;
          m_store = (lsb_op_type == S_TYPE); m_load = (lsb_op_type == LD_TYPE);
          x_wr = m_store; x_addr = lsb_addr; x_op = lsb_op; x_wdata = lsb_wdata;
          x_start = 1; x_lsb_ack = 1;
          if (if_req && m_starve < STARVE) m_starve++;
        end else if (!rob_clear_up && if_req) begin
          m_busy = 1; m_issuing = 1; m_cancel = 0; m_is_if = 1; m_store = 0; m_load = 0;
          x_wr = 0; x_addr = if_pc; x_op = 3'b010;
          x_start = 1; x_if_ack = 1;
          m_starve = 0;
        end
      end else if (m_issuing) begin
        m_issuing = 0;
        if (rob_clear_up && !m_store) m_cancel = 1;
      end else begin
        if (rob_clear_up && !m_store) m_cancel = 1;
        if (mu_done) begin
          if (!m_cancel) begin
            if (m_is_if) begin
              x_if_done = 1; x_if_inst = mu_rdata; x_if_addr = x_addr;
            end else begin
              x_lsb_done = 1; x_is_load = m_load; x_lsb_rdata = m_load ? mu_rdata : 32'd0;
            end
          end
          m_busy = 0; m_cancel = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_done(input bit want_if, input string name);
    int i = 0;
    while (i < 60 && !(want_if ? if_done : lsb_done)) begin
      step();
      i++;
    end
    check(name, want_if ? if_done : lsb_done, 1'b1);
  endtask

  task automatic lsb_drive(input logic [6:0] ty, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    lsb_req = 1; lsb_op_type = ty; lsb_op = op; lsb_addr = a; lsb_wdata = wd;
  endtask

  initial begin
    int starts0, hi, n_ifd, done_cyc, ack_cyc, g, n;
    logic [9:0] seq;

    repeat (3) step();
    rst_in = 0;
    step();
    check("rst_mu_start", mu_start, 0);
    check("rst_acks", {if_ack, lsb_ack}, 0);
    check("rst_dones", {if_done, lsb_done, lsb_is_load}, 0);
    check("rst_mu_addr", mu_addr, 0);

    // 1: plain load
    mu_lat = 2; mu_val = 32'hDEADBEEF;
    lsb_drive(LD_TYPE, 3'b010, 32'h100, 32'd0);
    step();
    check("t1_lsb_ack", lsb_ack, 1);
    check("t1_mu_start", mu_start, 1);
    check("t1_mu_addr", mu_addr, 32'h100);
    lsb_req = 0;
    wait_done(0, "t1_lsb_done");
    check("t1_is_load", lsb_is_load, 1);
    check("t1_rdata", lsb_rdata, 32'hDEADBEEF);
    step();

    // 2: both requesters held, expect L L L L I repeating
    mu_lat = 1; mu_val = 32'h0000_1234;
    lsb_drive(LD_TYPE, 3'b010, 32'h400, 32'd0);
    if_req = 1; if_pc = 32'h500;
    seq = '0; g = 0;
    for (int i = 0; i < 200 && g < 10; i++) begin
      step();
      if (lsb_ack) begin seq = {seq[8:0], 1'b1}; g++; end
      else if (if_ack) begin seq = {seq[8:0], 1'b0}; g++; end
    end
    if_req = 0; lsb_req = 0;
    check("t2_grant_count", g, 10);
    check("t2_grant_pattern", {22'd0, seq}, 32'b1111011110);
    wait_done(1, "t2_last_fetch");
    step();

    // 3: store is immune to a flush in WAIT
    mu_lat = 4;
    lsb_drive(S_TYPE, 3'b000, 32'h30004, 32'h41);
    step();
    check("t3_lsb_ack", lsb_ack, 1);
    lsb_req = 0;
    step();
    rob_clear_up = 1;
    step();
    rob_clear_up = 0;
    check("t3_mu_wr", mu_wr, 1);
    check("t3_mu_wdata", mu_wdata, 32'h41);
    wait_done(0, "t3_store_done");
    check("t3_not_load", lsb_is_load, 0);
    step();

    // 4: fetch flushed in WAIT, next fetch granted right after drain
    mu_lat = 4; mu_val = 32'h0000_0013;
    if_req = 1; if_pc = 32'h1000;
    step();
    check("t4_if_ack", if_ack, 1);
    if_req = 0;
    step();
    rob_clear_up = 1;
    step();
    rob_clear_up = 0;
    if_req = 1; if_pc = 32'h2000;
    done_cyc = -1; ack_cyc = -1; n_ifd = 0;
    for (int i = 0; i < 30 && ack_cyc < 0; i++) begin
      step();
      if (mu_done && done_cyc < 0) done_cyc = cyc;
      if (if_done) n_ifd++;
      if (if_ack) ack_cyc = cyc;
    end
    if_req = 0; mu_val = 32'hC0DE_0002;
    check("t4_no_if_done", n_ifd, 0);
    check("t4_ack_after_drain", ack_cyc, done_cyc + 2);
    wait_done(1, "t4_fetch2_done");
    check("t4_inst", if_inst, 32'hC0DE_0002);
    check("t4_inst_addr", if_inst_addr, 32'h2000);
    step();

    // 5: freeze in ISSUE
    mu_lat = 2; mu_val = 32'h5555_AAAA; starts0 = n_starts;
    lsb_drive(LD_TYPE, 3'b010, 32'h200, 32'd0);
    step();
    check("t5_lsb_ack", lsb_ack, 1);
    lsb_req = 0; rdy_in = 0; hi = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mu_start) hi++;
    end
    check("t5_start_held", hi, 5);
    rdy_in = 1;
    wait_done(0, "t5_lsb_done");
    check("t5_single_start", n_starts - starts0, 1);
    check("t5_rdata", lsb_rdata, 32'h5555_AAAA);
    step();

    // 6: reset during WAIT, then normal service
    mu_lat = 6;
    if_req = 1; if_pc = 32'h3000;
    step();
    if_req = 0;
    step();
    step();
    rst_in = 1;
    step();
    rst_in = 0;
    check("t6_pulses_zero", {mu_start, if_ack, lsb_ack, if_done, lsb_done}, 0);
    check("t6_mu_addr_zero", mu_addr, 0);
    check("t6_mu_op_zero", mu_op, 0);
    mu_lat = 2; mu_val = 32'h600D_F00D;
    if_req = 1; if_pc = 32'h3004;
    step();
    check("t6_if_ack", if_ack, 1);
    if_req = 0;
    wait_done(1, "t6_fetch_done");
    check("t6_inst", if_inst, 32'h600D_F00D);
    check("t6_inst_addr", if_inst_addr, 32'h3004);
    step();

    // 7: flush in IDLE blocks that cycle's grant only
    mu_lat = 1; mu_val = 32'h7777_0007;
    lsb_drive(LD_TYPE, 3'b100, 32'h300, 32'd0);
    rob_clear_up = 1;
    step();
    check("t7_no_grant_on_flush", lsb_ack, 0);
    rob_clear_up = 0;
    step();
    check("t7_grant_after", lsb_ack, 1);
    lsb_req = 0;
    wait_done(0, "t7_lsb_done");
    step();

    // 8: flush together with mu_done on a load suppresses the result
    mu_lat = 0; mu_val = 32'h8888_0008;
    lsb_drive(LD_TYPE, 3'b010, 32'h340, 32'd0);
    step();
    lsb_req = 0;
    step();
    rob_clear_up = 1;
    step();
    rob_clear_up = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (lsb_done) n++;
    end
    check("t8_done_suppressed", n, 0);
    mu_lat = 1;
    lsb_drive(LD_TYPE, 3'b010, 32'h380, 32'd0);
    step();
    check("t8_next_ack", lsb_ack, 1);
    lsb_req = 0;
    wait_done(0, "t8_next_done");
    check("t8_next_rdata", lsb_rdata, 32'h8888_0008);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
